// File: rtl/mem_cache_pkg.sv
// mem_cache_pkg: FSM states, derived widths and address-field helpers for mem_cache_unit
package mem_cache_pkg;
    typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;
    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction
    function automatic int tag_w(input int addr_w, input int sets);
        return addr_w - 3 - $clog2(sets);
    endfunction
    function automatic logic [63:0] addr_idx(input logic [63:0] a, input int iw);
        return (a >> 3) & ((64'd1 << iw) - 64'd1);
    endfunction
    function automatic logic [63:0] addr_tag(input logic [63:0] a, input int iw);
        return a >> (3 + iw);
    endfunction
endpackage

// File: rtl/mem_cache_array.sv
// mem_cache_array: 2-way valid/tag/line/LRU storage with combinational lookup
module mem_cache_array #(
    parameter int SETS   = 64,
    parameter int IDX_W  = 6,
    parameter int TAG_W  = 23,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                touch,
    input  logic                wr_en,
    input  logic                fill_en,
    input  logic [IDX_W-1:0]    idx,
    input  logic [TAG_W-1:0]    tag,
    input  logic                wsel,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [2*DATA_W-1:0] fill_line,
    output logic                hit,
    output logic                hit_way,
    output logic [DATA_W-1:0]   word
);
    logic [SETS-1:0]     valid [2];
    logic [SETS-1:0]     lru;
    logic [TAG_W-1:0]    tags  [2][SETS];
    logic [2*DATA_W-1:0] lines [2][SETS];
    logic                hit0, hit1, fill_way;
    logic [2*DATA_W-1:0] line;

    assign hit0     = valid[0][idx] && tags[0][idx] == tag;
    assign hit1     = valid[1][idx] && tags[1][idx] == tag;
    assign hit      = hit0 || hit1;
    assign hit_way  = hit1;
    assign line     = lines[hit_way][idx];
    assign word     = wsel ? line[2*DATA_W-1:DATA_W] : line[DATA_W-1:0];
    // empty ways are filled before any valid line is evicted
    assign fill_way = !valid[0][idx] ? 1'b0 : !valid[1][idx] ? 1'b1 : lru[idx];

    // valid bits and LRU pointer: the way just used is protected, the other becomes the victim
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid[0] <= '0;
            valid[1] <= '0;
            lru      <= '0;
        end else if (flush) begin
            valid[0] <= '0;
            valid[1] <= '0;
        end else if (fill_en) begin
            valid[fill_way][idx] <= 1'b1;
            lru[idx]             <= ~fill_way;
        end else if (touch && hit) begin
            lru[idx] <= ~hit_way;
        end
    end

    // tag/line storage: line fills on read-miss return, single-word update on write hit
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tags[fill_way][idx]  <= tag;
            lines[fill_way][idx] <= fill_line;
        end else if (wr_en && hit) begin
            lines[hit_way][idx][(wsel ? DATA_W : 0) +: DATA_W] <= wr_data;
        end
    end
endmodule

// File: rtl/mem_cache_unit.sv
// mem_cache_unit: 2-way write-through no-write-allocate data cache; CACHE_STATS_EN adds hit/miss counters
module mem_cache_unit import mem_cache_pkg::*; #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int SETS      = 64,
    parameter int BASE_ADDR = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_rd,
    input  logic                req_wr,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic [DATA_W-1:0]   rdata,
    output logic                ready,
    input  logic                flush,
    output logic                sram_rd_en,
    output logic                sram_wr_en,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]   sram_wdata,
    input  logic [2*DATA_W-1:0] sram_rdata,
    input  logic                sram_ready
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]         stat_hits,
    output logic [31:0]         stat_misses
`endif
);
    localparam int IDX_W  = idx_w(SETS);
    localparam int TAG_W  = tag_w(ADDR_W, SETS);
    localparam int LINE_W = 2 * DATA_W;

    state_t              state, next_state;
    logic [ADDR_W-1:0]   a_in, addr_q, la;
    logic [DATA_W-1:0]   wdata_q, word;
    logic                idle, hit, hit_way, rd_hit, touch, wr_en, fill;

    assign idle       = state == IDLE;
    assign a_in       = req_addr - ADDR_W'(BASE_ADDR);
    // IDLE looks up the live request; miss handling uses the captured address
    assign la         = idle ? a_in : addr_q;
    assign rd_hit     = idle && req_rd && !req_wr && !flush && hit;
    assign sram_rd_en = state == RD_MISS;
    assign sram_wr_en = state == WR_THRU;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;

    mem_cache_array #(.SETS(SETS), .IDX_W(IDX_W), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_array (
        .clk       (clk),
        .rst       (rst),
        .flush     (idle && flush),
        .touch     (touch),
        .wr_en     (wr_en),
        .fill_en   (fill),
        .idx       (IDX_W'(addr_idx(64'(la), IDX_W))),
        .tag       (TAG_W'(addr_tag(64'(la), IDX_W))),
        .wsel      (la[2]),
        .wr_data   (req_wdata),
        .fill_line (sram_rdata),
        .hit       (hit),
        .hit_way   (hit_way),
        .word      (word)
    );

    // next state, stall and array controls; a flush in IDLE forces the miss path for a concurrent request
    always_comb begin
        next_state = state;
        ready      = 1'b1;
        rdata      = '0;
        touch      = 1'b0;
        wr_en      = 1'b0;
        fill       = 1'b0;
        case (state)
            IDLE: begin
                if (req_wr) begin
                    next_state = WR_THRU;
                    ready      = 1'b0;
                    touch      = !flush;
                    wr_en      = !flush;
                end else if (req_rd && !rd_hit) begin
                    next_state = RD_MISS;
                    ready      = 1'b0;
                end else if (rd_hit) begin
                    rdata = word;
                    touch = 1'b1;
                end
            end
            RD_MISS: begin
                ready      = sram_ready;
                fill       = sram_ready;
                next_state = sram_ready ? IDLE : RD_MISS;
                rdata      = !sram_ready ? '0 : addr_q[2] ? sram_rdata[LINE_W-1:DATA_W] : sram_rdata[DATA_W-1:0];
            end
            WR_THRU: begin
                ready      = sram_ready;
                next_state = sram_ready ? IDLE : WR_THRU;
            end
            default: next_state = IDLE;
        endcase
    end

    // state register and request capture on leaving IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state <= next_state;
            if (idle && next_state != IDLE) begin
                addr_q  <= a_in;
                wdata_q <= req_wdata;
            end
        end
    end

`ifdef CACHE_STATS_EN
    // saturating read hit / read miss-fill counters, untouched by flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else begin
            if (rd_hit && stat_hits != '1) stat_hits <= stat_hits + 32'd1;
            if (fill && stat_misses != '1) stat_misses <= stat_misses + 32'd1;
        end
    end
`endif

`ifndef SYNTHESIS
    a_rd_wr_excl: assert property (@(posedge clk) disable iff (rst) !(req_rd && req_wr));
`endif
endmodule

// File: tb/tb_mem_cache_unit.sv
// tb_mem_cache_unit: scoreboard bench with a recency-list cache model and a behavioural SRAM
module tb_mem_cache_unit;
    typedef struct {
        logic        is_rd;
        logic        miss;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0, rst = 1'b1, req_rd = 1'b0, req_wr = 1'b0, flush = 1'b0, sram_ready = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [31:0] rdata, sram_addr, sram_wdata;
    logic        ready, sram_rd_en, sram_wr_en;
    logic [63:0] sram_rdata = '0;
`ifdef CACHE_STATS_EN
    logic [31:0] stat_hits, stat_misses;
`endif

    exp_t        exp_q[$];
    int          tests = 0, fails = 0, fixed_lat = -1, mdl_hits = 0, mdl_misses = 0;
    logic [63:0] ref_mem  [int unsigned];
    logic [63:0] sram_mem [int unsigned];
    logic [22:0] ways [64][$];

    mem_cache_unit dut (
        .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .rdata(rdata), .ready(ready), .flush(flush),
        .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ready(sram_ready)
`ifdef CACHE_STATS_EN
        , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] init_line(input int unsigned ln);
        return {(ln * 32'h9E37_79B9) ^ 32'h5A5A_0000, ln * 32'h0001_0003 + 32'h77};
    endfunction

    function automatic logic [63:0] ref_line(input int unsigned ln);
        return ref_mem.exists(ln) ? ref_mem[ln] : init_line(ln);
    endfunction

    function automatic logic [63:0] sram_line(input int unsigned ln);
        return sram_mem.exists(ln) ? sram_mem[ln] : init_line(ln);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic finish_up();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    endtask

    function automatic void clear_model();
        foreach (ways[i]) ways[i].delete();
    endfunction

    // reference: per set a most-recent-first list of at most two tags; memory is always coherent
    function automatic exp_t model(input logic is_rd, input logic [31:0] addr, input logic [31:0] wd, input logic fl);
        exp_t        e;
        logic [31:0] a = addr - 32'h400;
        int unsigned ln = a >> 3;
        int          s = int'(a[8:3]);
        logic [22:0] t = a[31:9];
        logic [63:0] line = ref_line(ln);
        int          pos = -1;
        if (fl) clear_model();
        for (int i = 0; i < ways[s].size(); i++) if (ways[s][i] == t) pos = i;
        e.is_rd = is_rd;
        e.miss  = is_rd && pos < 0;
        e.data  = '0;
        if (is_rd) begin
            if (pos >= 0) ways[s].delete(pos);
            ways[s].push_front(t);
            if (ways[s].size() > 2) ways[s].delete(2);
            e.data = a[2] ? line[63:32] : line[31:0];
            if (e.miss) mdl_misses++;
            else mdl_hits++;
        end else begin
            if (pos >= 0) begin
                ways[s].delete(pos);
                ways[s].push_front(t);
            end
            if (a[2]) line[63:32] = wd;
            else line[31:0] = wd;
            ref_mem[ln] = line;
        end
        return e;
    endfunction

    task automatic do_req(input logic is_wr, input logic [31:0] addr, input logic [31:0] wd, input logic fl);
        int n = 0;
        exp_q.push_back(model(!is_wr, addr, wd, fl));
        req_rd = !is_wr; req_wr = is_wr; req_addr = addr; req_wdata = wd; flush = fl;
        forever begin
            @(negedge clk);
            if (ready) break;
            if (++n > 50) begin
                $display("FAIL timeout: ready never rose for addr %h", addr);
                fails++;
                finish_up();
            end
            @(posedge clk); #1;
            flush = 1'b0;
        end
        @(posedge clk); #1;
        req_rd = 1'b0; req_wr = 1'b0; flush = 1'b0;
    endtask

    task automatic do_flush();
        clear_model();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    // behavioural SRAM: answers a held enable after 0..3 extra cycles with a one-cycle ready pulse
    initial begin
        forever begin
            @(posedge clk); #1;
            sram_ready = 1'b0;
            if (!rst && (sram_rd_en || sram_wr_en)) begin
                repeat (fixed_lat >= 0 ? fixed_lat : int'($urandom_range(0, 3))) begin
                    @(posedge clk); #1;
                end
                if (sram_rd_en) begin
                    sram_rdata = sram_line(sram_addr >> 3);
                    sram_ready = 1'b1;
                end else if (sram_wr_en) begin
                    logic [63:0] l = sram_line(sram_addr >> 3);
                    if (sram_addr[2]) l[63:32] = sram_wdata;
                    else l[31:0] = sram_wdata;
                    sram_mem[sram_addr >> 3] = l;
                    sram_ready = 1'b1;
                end
            end
        end
    end

    // monitor: pops the scoreboard whenever a request completes
    initial begin
        logic saw_rd = 1'b0, saw_wr = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                saw_rd = 1'b0; saw_wr = 1'b0;
            end else if (req_rd || req_wr) begin
                saw_rd |= sram_rd_en;
                saw_wr |= sram_wr_en;
                if (ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_completion", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.is_rd) begin
                            chk($sformatf("rdata@%h", req_addr), rdata, e.data);
                            chk($sformatf("rd_miss@%h", req_addr), saw_rd, e.miss);
                        end else begin
                            chk($sformatf("wr_thru@%h", req_addr), {saw_wr, saw_rd}, 2'b10);
                        end
                    end
                    saw_rd = 1'b0; saw_wr = 1'b0;
                end
            end
        end
    end

    initial begin
        sram_mem[0] = 64'h2222_2222_1111_1111;
        ref_mem[0]  = 64'h2222_2222_1111_1111;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_rdata", rdata, 0);
        chk("rst_rd_en", sram_rd_en, 0);
        chk("rst_wr_en", sram_wr_en, 0);
        chk("rst_sram_addr", sram_addr, 0);
        chk("rst_sram_wdata", sram_wdata, 0);
        @(posedge clk); #1;
        // miss then hit on the preloaded line, LRU eviction in set 0, write hit / write miss
        do_req(0, 32'h404, 0, 0);
        do_req(0, 32'h400, 0, 0);
        do_req(0, 32'h600, 0, 0);
        do_req(0, 32'h400, 0, 0);
        do_req(0, 32'h800, 0, 0);
        do_req(0, 32'h404, 0, 0);
        do_req(0, 32'h600, 0, 0);
        do_req(1, 32'h404, 32'hDEAD_BEEF, 0);
        do_req(0, 32'h404, 0, 0);
        do_req(1, 32'hC08, 32'h1234_5678, 0);
        do_req(0, 32'hC08, 0, 0);
        // reset in the middle of a read miss
        fixed_lat = 6;
        req_rd = 1'b1; req_addr = 32'h1000;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("miss_rd_en", sram_rd_en, 1);
        @(posedge clk); #1;
        req_rd = 1'b0; rst = 1'b1;
        #1;
        chk("rst_mid_rd_en", sram_rd_en, 0);
        chk("rst_mid_ready", ready, 1);
        clear_model();
        mdl_hits = 0; mdl_misses = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        fixed_lat = -1;
        do_req(0, 32'h1000, 0, 0);
        do_req(0, 32'h404, 0, 0);
        do_req(0, 32'h1000, 0, 0);
        do_flush();
        do_req(0, 32'h1000, 0, 0);
        do_req(0, 32'h404, 0, 0);
        // randomized mix of reads, writes and flushes over a few tags/sets
        for (int i = 0; i < 400; i++) begin
            int          r = int'($urandom_range(0, 99));
            logic [31:0] addr = 32'h400 + ($urandom_range(0, 3) << 9) + ($urandom_range(0, 3) << 3)
                                + ($urandom_range(0, 1) << 2) + $urandom_range(0, 3);
            if (r < 5) do_flush();
            else do_req(r >= 72, addr, $urandom, r < 9);
        end
        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_empty", exp_q.size(), 0);
`ifdef CACHE_STATS_EN
        chk("stat_hits", stat_hits, mdl_hits);
        chk("stat_misses", stat_misses, mdl_misses);
`endif
        finish_up();
    end
endmodule
